jk_bank_arbiter: RTL
====================

# jk_bank_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit bank of JK storage elements between N_REQ requesters. Each requester presents per-bit J/K command vectors. The arbiter picks one winner, captures its vectors, and commits them to the bank with JK semantics: 00 hold, 01 reset, 10 set, 11 toggle. The block sits between command-issuing masters and the shared JK state register, and it is the only writer of that register.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, bits in the shared JK bank
- IDW, $clog2(N_REQ), grant index width (derived, not overridable)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  bit i: requester i has a pending command
- req_j  in  N_REQ*WIDTH  requester i's J vector in slice [i*WIDTH +: WIDTH]
- req_k  in  N_REQ*WIDTH  requester i's K vector, same slicing
- req_ack  out  N_REQ  one-hot, one-cycle pulse: command of requester i committed
- grant_id  out  IDW  index of the current or most recent winner
- busy  out  1  high while a captured command is in APPLY
- q  out  WIDTH  shared bank state
- qbar  out  WIDTH  bitwise ~q, combinational

## Operation
- FSM has two states:
  - IDLE: sample req_valid. If any bit is set, choose the winner, capture req_j/req_k of the winner into internal registers, load grant_id, and go to APPLY. If none is set, stay in IDLE.
  - APPLY: update each bank bit from the captured vectors: q[b] <= j?(k?~q[b]:1):(k?0:q[b]). Pulse req_ack[winner] high this cycle. Always return to IDLE.
- Arbitration is round-robin from pointer ptr.
  - Scan indices ptr, ptr+1, … mod N_REQ; the first with req_valid set wins.
  - After capture, ptr <= (winner+1) mod N_REQ.
  - ptr does not change when there is no request.
- Handshake:
  - A requester holds req_valid and its vectors stable until it sees req_ack.
  - A command is committed exactly once.
  - If req_valid or the vectors change after capture, the captured values still commit.
  - A requester may assert a new command in the cycle after its ack.
- Bits with j=k=0 are untouched, so several requesters can own disjoint bit fields.
- busy = (state == APPLY).
- grant_id holds its value through IDLE until the next capture.

## Timing
- Reset values: q=0 (qbar all ones), req_ack=0, grant_id=0, busy=0, ptr=0, state=IDLE, captured j/k=0.
- Latency: request sampled in IDLE at edge t; APPLY during cycle t+1; q shows the new value and req_ack deasserts after edge t+2. req_ack is high during the cycle before q updates.
- Throughput: one command per 2 cycles. Under continuous contention each requester is served once every 2*N_REQ cycles. There is no starvation.
- Requests arriving during APPLY are not sampled. They are considered in the following IDLE cycle.
- Simultaneous requests: winner is the first valid index at or after ptr, with wrap-around, e.g. ptr=3 with valid=0b1001 selects 3, then ptr=0.
- rst asserted during APPLY aborts the commit: q is cleared to 0 and no ack is issued. rst has priority over all other activity.
- After a captured command commits, no residual state from it remains.

## Structure
- Shared package jk_pkg holds:
  - the JK op encoding constants (JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11)
  - the FSM state enum (ST_IDLE, ST_APPLY)
  - a jk_next(q,j,k) function shared with future JK blocks
- One natural sub-module is rr_picker, the combinational round-robin first-one finder. Inputs: req, ptr. Outputs: found, idx. It is reused by later arbiters.
- The bank register and the FSM stay in the top module.

## Test plan
All scenarios use N_REQ=4, WIDTH=8.
- Reset: hold rst 2 cycles → q=0x00, qbar=0xFF, req_ack=0, busy=0, grant_id=0. Then assert rst during an APPLY → q=0x00 next cycle and no ack.
- Single op sequence: requester 1 issues j=0xFF k=0x00 → q=0xFF, req_ack=0b0010 one cycle. Then j=0x0F k=0x0F → q=0xF0. Then j=0x00 k=0x0F → q=0xF0 unchanged.
- Contention: all four valid from reset, each set j=k=1<<i → acks in order 0,1,2,3, spaced 2 cycles apart. Final q=0x0F.
- Wrap-around: ptr=3 with valid=0b1001 → grant 3 then 0. Requester 0 then holds valid continuously → it is granted every 2 cycles and no other requester appears.
- Data changes after capture: requester 2 changes j/k during APPLY → the originally captured values commit. Requester 2 keeps valid high → a second ack with the new values follows.
- Hold: a command with j=k=0x00 → ack issued, q unchanged. Check qbar == ~q on every cycle.

Source files
------------

// File: rtl/jk_bank_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for JK storage blocks.
//   JK_*        : two-bit {j,k} operation encodings
//   jk_state_e  : sequencer FSM states
//   jk_next()   : next value of one JK bit given its current value and {j,k}
// ---------------------------------------------------------------------------
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } jk_state_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            JK_HOLD:   r = q;
            JK_RESET:  r = 1'b0;
            JK_SET:    r = 1'b1;
            JK_TOGGLE: r = ~q;
            default:   r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter_if
// Bundle between the command-issuing requesters (master) and the shared JK
// bank arbiter (slave).
//   req_valid [N_REQ]        : requester i has a pending command
//   req_j/req_k [N_REQ*WIDTH]: requester i's vectors in slice [i*WIDTH +: WIDTH]
//   req_ack [N_REQ]          : one-hot, one-cycle commit pulse
//   grant_id [IDW]           : current or most recent winner
//   busy                     : a captured command is being applied
//   q / qbar [WIDTH]         : shared bank state and its complement
//
// Handshake: a requester raises req_valid with its vectors and holds both
// stable until it sees its req_ack bit high; the command is committed exactly
// once, at the clock edge that closes the ack cycle. The next command may be
// presented from the cycle after the ack.
// ---------------------------------------------------------------------------
interface jk_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_j;
    logic [N_REQ*WIDTH-1:0] req_k;
    logic [N_REQ-1:0]       req_ack;
    logic [IDW-1:0]         grant_id;
    logic                   busy;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       qbar;

    modport master (
        output req_valid, req_j, req_k,
        input  req_ack, grant_id, busy, q, qbar
    );

    modport slave (
        input  req_valid, req_j, req_k,
        output req_ack, grant_id, busy, q, qbar
    );

endinterface

// File: rtl/jk_bank_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin first-one finder.
//   i_req [N_REQ] : request vector
//   i_ptr [IDW]   : index where the scan starts (highest priority)
//   o_found       : at least one request is set
//   o_idx [IDW]   : first set index at or after i_ptr, with wrap-around
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic             o_found,
    output logic [IDW-1:0]   o_idx
);

    // Scan from the farthest offset down to offset 0 so the nearest set
    // request (lowest offset from the pointer) is the last one written.
    always_comb begin
        int pos;
        pos     = 0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            pos = (int'(i_ptr) + off) % N_REQ;
            if (i_req[pos]) begin
                o_found = 1'b1;
                o_idx   = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter
// Round-robin arbiter that shares one WIDTH-bit JK bank between N_REQ
// requesters. IDLE captures the winner's J/K vectors; APPLY commits them
// to the bank with JK semantics and pulses the winner's ack.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, overrides everything (aborts an
//          in-flight commit and suppresses its ack)
//   bus  : jk_bank_arbiter_if slave modport (requests, acks, grant, bank)
// busy doubles as the FSM state observation point (high in APPLY).
// ---------------------------------------------------------------------------
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    jk_bank_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [0:0] S_IDLE  = 1'(ST_IDLE);
    localparam logic [0:0] S_APPLY = 1'(ST_APPLY);

    logic [0:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_grant;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_q;

    logic             w_found;
    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_ptr_next;
    logic [WIDTH-1:0] w_q_next;
    logic [N_REQ-1:0] w_ack;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_picker (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_ptr_next = (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_q_next = r_q;
        for (int b = 0; b < WIDTH; b++) begin
            w_q_next[b] = jk_next(r_q[b], r_j[b], r_k[b]);
        end
    end

    // The ack is gated by rst so that a reset landing on the APPLY cycle
    // never shows a commit that is about to be discarded.
    always_comb begin
        w_ack = '0;
        if (r_state == S_APPLY && !rst) begin
            w_ack[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_q     <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                r_j     <= bus.req_j[int'(w_idx) * WIDTH +: WIDTH];
                r_k     <= bus.req_k[int'(w_idx) * WIDTH +: WIDTH];
                r_grant <= w_idx;
                r_ptr   <= w_ptr_next;
                r_state <= S_APPLY;
            end
        end else begin
            // Commit, then drop the captured vectors so nothing of this
            // command lingers into the next one.
            r_q     <= w_q_next;
            r_j     <= '0;
            r_k     <= '0;
            r_state <= S_IDLE;
        end
    end

    assign bus.req_ack  = w_ack;
    assign bus.grant_id = r_grant;
    assign bus.busy     = (r_state == S_APPLY);
    assign bus.q        = r_q;
    assign bus.qbar     = ~r_q;

endmodule
